// File: rtl/mult_share_pkg.sv
// mult_share_pkg
//   Shared definitions for the shared-multiplier controller:
//   - FSM state encoding for mult_share_ctrl
//   - default requester count and multiplier timeout
//   - helper for sizing requester index fields
package mult_share_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int TMO_DEFAULT  = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Width of an index into n requesters; at least one bit so a
    // single-requester build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin selector. Scans the request vector
//   starting at index ptr, wrapping around, and reports the first active
//   requester as a one-hot winner.
// Ports:
//   req   - request levels, one bit per requester
//   ptr   - index that has highest priority this round
//   win   - one-hot winner (zero when no request)
//   valid - at least one request is active
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    // Two passes instead of modular index arithmetic: first the indices at
    // or above ptr, then the ones below it, which is the wrapped order.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                win[i] = 1'b1;
                valid  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (i < int'(ptr))) begin
                win[i] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Lets NREQ requesters share one sequential 4x4 multiplier. One request
//   is served per operation, chosen round-robin. Each operation walks
//   IDLE -> LOAD -> START -> WAIT -> DONE -> IDLE. A multiplier that does
//   not answer within TMO WAIT cycles produces a DONE with ERR set and a
//   zero product. Every output comes straight from a register.
// Ports:
//   CK, RSTN         - clock, asynchronous active-low reset
//   REQ              - per-requester request level
//   A_IN, B_IN       - packed 4-bit operands, requester i in [4i+3:4i]
//   GNT              - one-hot grant, held from LOAD through DONE
//   DONE             - one-cycle completion pulse to the granted requester
//   P_OUT, ERR       - product and timeout flag, valid while DONE is set
//   BUSY             - controller is not idle
//   MUL_START        - one-cycle start strobe to the multiplier
//   MUL_A, MUL_B     - multiplier operands, stable from LOAD through DONE
//   MUL_READY, MUL_P - multiplier completion and product
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int TMO  = TMO_DEFAULT
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic [NREQ-1:0]   REQ,
    input  logic [4*NREQ-1:0] A_IN,
    input  logic [4*NREQ-1:0] B_IN,
    output logic [NREQ-1:0]   GNT,
    output logic [NREQ-1:0]   DONE,
    output logic [7:0]        P_OUT,
    output logic              ERR,
    output logic              BUSY,
    output logic              MUL_START,
    output logic [3:0]        MUL_A,
    output logic [3:0]        MUL_B,
    input  logic              MUL_READY,
    input  logic [7:0]        MUL_P
);

    localparam int PW = idx_width(NREQ);
    localparam int CW = $clog2(TMO + 1);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    // Counter value in the last WAIT cycle before the timeout fires.
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
    localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_idx;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] arb_win;
    logic            arb_valid;
    logic [PW-1:0]   sel_idx;
    logic [3:0]      sel_a;
    logic [3:0]      sel_b;
    logic            rdy_ok;
    logic            tmo_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (REQ),
        .ptr   (ptr),
        .win   (arb_win),
        .valid (arb_valid)
    );

    // Operand slices and index of the arbitration winner.
    always_comb begin
        sel_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_win[i]) begin
                sel_idx = PW'(i);
                sel_a   = A_IN[4*i +: 4];
                sel_b   = B_IN[4*i +: 4];
            end
        end
    end

    // The counter is zero only in the first WAIT cycle, so it doubles as
    // the "ignore MUL_READY" qualifier. A ready in the last allowed cycle
    // wins over the timeout.
    always_comb begin
        rdy_ok  = (state == S_WAIT) && (cnt != '0) && MUL_READY;
        tmo_hit = (state == S_WAIT) && !rdy_ok && (cnt == TMO_LAST);
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (arb_valid) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (rdy_ok || tmo_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs. Grant and operands are captured on the edge into
    // LOAD so they are already stable throughout LOAD; DONE, P_OUT and ERR
    // are set on the edge into DONE and DONE/ERR/GNT drop on the way out.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            ptr       <= '0;
            win_idx   <= '0;
            cnt       <= '0;
            GNT       <= '0;
            DONE      <= '0;
            P_OUT     <= '0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
            MUL_START <= 1'b0;
            MUL_A     <= '0;
            MUL_B     <= '0;
        end else begin
            MUL_START <= (state == S_LOAD);
            BUSY      <= (state_nxt != S_IDLE);
            unique case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        GNT     <= arb_win;
                        win_idx <= sel_idx;
                        MUL_A   <= sel_a;
                        MUL_B   <= sel_b;
                    end
                end
                S_START: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (rdy_ok) begin
                        P_OUT <= MUL_P;
                        ERR   <= 1'b0;
                        DONE  <= GNT;
                    end else if (tmo_hit) begin
                        P_OUT <= '0;
                        ERR   <= 1'b1;
                        DONE  <= GNT;
                    end
                end
                S_DONE: begin
                    DONE <= '0;
                    ERR  <= 1'b0;
                    GNT  <= '0;
                    // The winner moves to lowest priority for the next round.
                    if (win_idx == IDX_LAST) begin
                        ptr <= '0;
                    end else begin
                        ptr <= win_idx + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_share_ctrl.md
MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one sequential 4x4 multiplier.
REQ-002 SHALL have parameter TMO, default 15, maximum cycles to wait for MUL_READY after MUL_START.
REQ-003 SHALL have port CK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port REQ  input  NREQ  per-requester request level.
REQ-006 SHALL have port A_IN  input  4*NREQ  multiplicand, requester i in bits [4i+3:4i].
REQ-007 SHALL have port B_IN  input  4*NREQ  multiplier, same packing as A_IN.
REQ-008 SHALL have port GNT  output  NREQ  one-hot grant; zero when idle.
REQ-009 SHALL have port DONE  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port P_OUT  output  8  product, valid while DONE is nonzero.
REQ-011 SHALL have port ERR  output  1  asserted with DONE when the operation timed out.
REQ-012 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-013 SHALL have port MUL_START  output  1  start strobe to the multiplier.
REQ-014 SHALL have ports MUL_A and MUL_B  output  4 each  operands to the multiplier.
REQ-015 SHALL have port MUL_READY  input  1  multiplier completion.
REQ-016 SHALL have port MUL_P  input  8  multiplier product.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, START, WAIT, DONE.
REQ-018 IDLE: when REQ is nonzero, SHALL select a winner round-robin, starting at index PTR, and go to LOAD; otherwise SHALL stay in IDLE.
REQ-019 LOAD: SHALL assert GNT[winner] and register A_IN/B_IN slices of the winner into MUL_A/MUL_B, then go to START.
REQ-020 START: SHALL drive MUL_START=1 for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-021 MUL_A/MUL_B SHALL stay constant from LOAD through DONE.
REQ-022 WAIT: SHALL ignore MUL_READY in the first WAIT cycle; afterwards MUL_READY=1 SHALL capture MUL_P into P_OUT and go to DONE.
REQ-023 WAIT: the counter SHALL increment every cycle; when it reaches TMO without MUL_READY, SHALL set ERR, set P_OUT=0 and go to DONE.
REQ-024 DONE: SHALL pulse DONE[winner] for one cycle with P_OUT/ERR valid, set PTR=(winner+1) mod NREQ, and drop GNT; next state IDLE.
REQ-025 GNT SHALL stay asserted from LOAD through DONE inclusive.
REQ-026 Latency: with REQ rising in IDLE at cycle N and a multiplier ready at cycle N+3+k, DONE SHALL pulse at N+4+k.
REQ-027 REQ deasserted after LOAD SHALL NOT abort the operation; DONE SHALL still pulse.
REQ-028 REQ deasserted while IDLE SHALL withdraw the request with no grant.
REQ-029 Simultaneous requests SHALL be served one per operation in round-robin order; no requester SHALL wait more than NREQ-1 operations.
REQ-030 A requester that holds REQ high through DONE SHALL re-enter arbitration, at lowest priority after the PTR update.
REQ-031 MUL_READY while the FSM is in IDLE, LOAD or START SHALL be ignored.
REQ-032 The timeout counter SHALL be ceil(log2(TMO+1)) bits and SHALL saturate, never wrap.

Reset
REQ-033 RSTN low SHALL immediately force: state IDLE, PTR=0, GNT=0, DONE=0, P_OUT=0, ERR=0, BUSY=0, MUL_START=0, MUL_A=0, MUL_B=0, counter=0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no DONE pulse.
REQ-035 The first rising CK after RSTN deassertion SHALL evaluate IDLE normally.

Structure
REQ-036 Package mult_share_pkg SHALL hold the FSM state enum and the default NREQ and TMO constants.
REQ-037 The round-robin selection SHALL be sub-module rr_arbiter, with inputs REQ and PTR and outputs a one-hot winner and a valid flag, purely combinational.
REQ-038 All outputs SHALL be driven from registers; there SHALL be no combinational path from REQ to GNT.

Verification
REQ-039 Test: REQ=0001, A0=3, B0=5, MUL_READY 5 cycles after START -> GNT=0001 from LOAD; DONE=0001 once; P_OUT=15; ERR=0.
REQ-040 Test: REQ=1111 held, operands i*2 and i+1 -> DONE order 0,1,2,3,0; products 0,4,12,24; GNT never multi-hot.
REQ-041 Test: MUL_READY tied 0 -> DONE pulses exactly TMO=15 cycles after the first WAIT cycle; ERR=1; P_OUT=0.
REQ-042 Test: RSTN pulsed low in WAIT -> all outputs 0 asynchronously; no DONE; next REQ is served from index 0.
REQ-043 Test: REQ=0100 dropped after 1 IDLE cycle before LOAD is taken -> no action; REQ dropped during WAIT -> DONE still pulses.
REQ-044 Test: MUL_READY=1 during START and in the first WAIT cycle -> ignored; capture occurs only on a later MUL_READY=1.
